// File: rtl/can_rx_fifo_if.sv
// Bundles the CAN receiver frame strobe and the peripheral register bus.
// The master side is the CAN core plus CPU bus; the slave side is the frame FIFO.
interface can_rx_fifo_if;
  logic        frm_valid;
  logic [28:0] frm_id;
  logic        frm_ext;
  logic        frm_rtr;
  logic [3:0]  frm_dlc;
  logic [63:0] frm_data;
  logic        cs;
  logic [2:0]  rs;
  logic [3:0]  bytesel;
  logic [31:0] d;
  logic [31:0] q;
  logic        irq;

  modport master (
    output frm_valid, frm_id, frm_ext, frm_rtr, frm_dlc, frm_data,
    output cs, rs, bytesel, d,
    input  q, irq
  );

  modport slave (
    input  frm_valid, frm_id, frm_ext, frm_rtr, frm_dlc, frm_data,
    input  cs, rs, bytesel, d,
    output q, irq
  );
endinterface

// File: rtl/can_rx_fifo.sv
// Receive FIFO for accepted CAN frames with an acceptance filter,
// sticky overflow flag and a small register interface.
module can_rx_fifo #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  can_rx_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [1:0]       irqen;
  logic [31:0]      acode;
  logic [31:0]      amask;

  logic [28:0] mem_id   [DEPTH];
  logic        mem_ext  [DEPTH];
  logic        mem_rtr  [DEPTH];
  logic [3:0]  mem_dlc  [DEPTH];
  logic [63:0] mem_data [DEPTH];

  logic        empty;
  logic        full;
  logic        wr_en;
  logic        ctrl_wr;
  logic        pop;
  logic        ovf_clr;
  logic        accept;
  logic        push;
  logic        ovf_set;
  logic [31:0] filt_key;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign wr_en    = bus.cs && (bus.bytesel != 4'b0000);
  assign ctrl_wr  = wr_en && (bus.rs == 3'd1);
  assign pop      = ctrl_wr && bus.bytesel[1] && bus.d[8] && !empty;
  assign ovf_clr  = ctrl_wr && bus.bytesel[0] && bus.d[6];
  assign filt_key = {bus.frm_ext, 2'b00, bus.frm_id};
  assign accept   = (((filt_key ^ acode) & amask) == 32'd0);
  // A pop in the same cycle frees the slot, so a full FIFO can still take the frame.
  assign push     = bus.frm_valid && accept && (!full || pop);
  assign ovf_set  = bus.frm_valid && accept && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      irqen <= 2'b00;
      acode <= 32'd0;
      amask <= 32'd0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (ctrl_wr && bus.bytesel[2]) irqen <= bus.d[17:16];
      for (int i = 0; i < 4; i++) begin
        if (wr_en && bus.rs == 3'd4 && bus.bytesel[i]) acode[8*i +: 8] <= bus.d[8*i +: 8];
        if (wr_en && bus.rs == 3'd5 && bus.bytesel[i]) amask[8*i +: 8] <= bus.d[8*i +: 8];
      end
    end
  end

  // Entry storage carries no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[tail]   <= bus.frm_id;
      mem_ext[tail]  <= bus.frm_ext;
      mem_rtr[tail]  <= bus.frm_rtr;
      mem_dlc[tail]  <= bus.frm_dlc;
      mem_data[tail] <= bus.frm_data;
    end
  end

  logic [28:0] hd_id;
  logic        hd_ext;
  logic        hd_rtr;
  logic [3:0]  hd_dlc;
  logic [63:0] hd_data;

  always_comb begin
    hd_id   = '0;
    hd_ext  = 1'b0;
    hd_rtr  = 1'b0;
    hd_dlc  = '0;
    hd_data = '0;
    if (!empty) begin
      hd_id   = mem_id[head];
      hd_ext  = mem_ext[head];
      hd_rtr  = mem_rtr[head];
      hd_dlc  = mem_dlc[head];
      hd_data = mem_data[head];
    end
  end

  always_comb begin
    bus.q = 32'd0;
    if (bus.cs) begin
      case (bus.rs)
        3'd0:    bus.q = {hd_ext, hd_rtr, 1'b0, hd_id};
        3'd1:    bus.q = {14'd0, irqen, 3'd0, 5'(count), 1'b0, ovf, full, empty, hd_dlc};
        3'd2:    bus.q = hd_data[31:0];
        3'd3:    bus.q = hd_data[63:32];
        3'd4:    bus.q = acode;
        3'd5:    bus.q = amask;
        default: bus.q = 32'd0;
      endcase
    end
  end

  assign bus.irq = (irqen[0] & ~empty) | (irqen[1] & ovf);

endmodule

// File: tb/tb_can_rx_fifo.sv
// Directed bench for can_rx_fifo (DEPTH=4): register map, filtering,
// overflow, simultaneous push/pop, interrupts and asynchronous reset.
module tb_can_rx_fifo;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  can_rx_fifo_if bus ();

  can_rx_fifo #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus: optional frame strobe plus optional register write.
  task automatic step(input logic fv, input logic [28:0] id, input logic ext, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] data,
                      input logic wcs, input logic [2:0] wrs, input logic [3:0] wbs,
                      input logic [31:0] wd);
    @(negedge clk);
    bus.frm_valid = fv;
    bus.frm_id    = id;
    bus.frm_ext   = ext;
    bus.frm_rtr   = rtr;
    bus.frm_dlc   = dlc;
    bus.frm_data  = data;
    bus.cs        = wcs;
    bus.rs        = wrs;
    bus.bytesel   = wbs;
    bus.d         = wd;
    @(negedge clk);
    bus.frm_valid = 1'b0;
    bus.cs        = 1'b0;
    bus.bytesel   = 4'b0000;
  endtask

  task automatic push(input logic [28:0] id, input logic ext, input logic [3:0] dlc,
                      input logic [63:0] data);
    step(1'b1, id, ext, 1'b0, dlc, data, 1'b0, 3'd0, 4'b0000, 32'd0);
  endtask

  task automatic wr(input logic [2:0] r, input logic [3:0] bs, input logic [31:0] v);
    step(1'b0, 29'd0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, r, bs, v);
  endtask

  task automatic pop();
    wr(3'd1, 4'b0010, 32'h0000_0100);
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] v);
    @(negedge clk);
    bus.cs      = 1'b1;
    bus.rs      = r;
    bus.bytesel = 4'b0000;
    #1;
    v = bus.q;
    bus.cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL reset_stat got %h exp %h", v, 32'h10); fails++; end
    rd(3'd0, v); tests++;
    if (v !== 32'h0) begin $display("FAIL reset_id got %h exp 0", v); fails++; end
    rd(3'd5, v); tests++;
    if (v !== 32'h0) begin $display("FAIL reset_amask got %h exp 0", v); fails++; end
    rd(3'd4, v); tests++;
    if (v !== 32'h0) begin $display("FAIL reset_acode got %h exp 0", v); fails++; end
    #1; tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL reset_irq got %b exp 0", bus.irq); fails++; end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    push(29'h123, 1'b0, 4'd8, 64'h8877_6655_4433_2211);
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0108) begin $display("FAIL basic_stat got %h exp %h", v, 32'h108); fails++; end
    rd(3'd0, v); tests++;
    if (v !== 32'h0000_0123) begin $display("FAIL basic_id got %h exp %h", v, 32'h123); fails++; end
    rd(3'd2, v); tests++;
    if (v !== 32'h4433_2211) begin $display("FAIL basic_data0 got %h exp %h", v, 32'h44332211); fails++; end
    rd(3'd3, v); tests++;
    if (v !== 32'h8877_6655) begin $display("FAIL basic_data1 got %h exp %h", v, 32'h88776655); fails++; end
    pop();
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL basic_stat_after_pop got %h exp %h", v, 32'h10); fails++; end
    rd(3'd0, v); tests++;
    if (v !== 32'h0) begin $display("FAIL basic_id_empty got %h exp 0", v); fails++; end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 1; i <= 5; i++)
      push(29'(i), 1'b0, 4'(i), {32'h0, 32'hD000_0000 + 32'(i)});
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0461) begin $display("FAIL ovf_stat got %h exp %h", v, 32'h461); fails++; end
    for (int i = 1; i <= 4; i++) begin
      rd(3'd0, v); tests++;
      if (v !== 32'(i)) begin $display("FAIL ovf_pop_id%0d got %h exp %h", i, v, 32'(i)); fails++; end
      rd(3'd2, v); tests++;
      if (v !== 32'hD000_0000 + 32'(i)) begin
        $display("FAIL ovf_pop_data%0d got %h exp %h", i, v, 32'hD000_0000 + 32'(i)); fails++;
      end
      pop();
    end
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0050) begin $display("FAIL ovf_sticky got %h exp %h", v, 32'h50); fails++; end
    wr(3'd1, 4'b0001, 32'h0000_0040);
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL ovf_clear got %h exp %h", v, 32'h10); fails++; end
  endtask

  task automatic test_ovf_set_wins();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) push(29'h20 + 29'(i), 1'b0, 4'd0, 64'd0);
    step(1'b1, 29'h30, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 3'd1, 4'b0001, 32'h0000_0040);
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0460) begin $display("FAIL ovf_set_wins got %h exp %h", v, 32'h460); fails++; end
    repeat (4) pop();
    wr(3'd1, 4'b0001, 32'h0000_0040);
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL ovf_set_wins_drain got %h exp %h", v, 32'h10); fails++; end
  endtask

  task automatic test_filter();
    logic [31:0] v;
    wr(3'd5, 4'b1111, 32'h8000_07FF);
    wr(3'd4, 4'b1111, 32'h0000_0100);
    step(1'b1, 29'h100, 1'b0, 1'b1, 4'd15, 64'hFFEE_DDCC_BBAA_9988, 1'b0, 3'd0, 4'b0000, 32'd0);
    push(29'h101, 1'b0, 4'd1, 64'd1);
    push(29'h100, 1'b1, 4'd2, 64'd2);
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_010F) begin $display("FAIL filt_stat got %h exp %h", v, 32'h10F); fails++; end
    rd(3'd0, v); tests++;
    if (v !== 32'h4000_0100) begin $display("FAIL filt_id got %h exp %h", v, 32'h40000100); fails++; end
    rd(3'd3, v); tests++;
    if (v !== 32'hFFEE_DDCC) begin $display("FAIL filt_data1 got %h exp %h", v, 32'hFFEEDDCC); fails++; end
    rd(3'd5, v); tests++;
    if (v !== 32'h8000_07FF) begin $display("FAIL filt_amask got %h exp %h", v, 32'h800007FF); fails++; end
    wr(3'd5, 4'b0100, 32'h1234_5678);
    rd(3'd5, v); tests++;
    if (v !== 32'h8034_07FF) begin $display("FAIL filt_lane got %h exp %h", v, 32'h803407FF); fails++; end
    wr(3'd5, 4'b1111, 32'h0);
    wr(3'd4, 4'b1111, 32'h0);
    pop();
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL filt_drain got %h exp %h", v, 32'h10); fails++; end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) push(29'h10 + 29'(i), 1'b0, 4'd2, 64'd0);
    step(1'b1, 29'h14, 1'b0, 1'b0, 4'd2, 64'd0, 1'b1, 3'd1, 4'b0010, 32'h0000_0100);
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0422) begin $display("FAIL fpp_stat got %h exp %h", v, 32'h422); fails++; end
    for (int k = 0; k < 4; k++) begin
      rd(3'd0, v); tests++;
      if (v !== 32'h11 + 32'(k)) begin $display("FAIL fpp_id%0d got %h exp %h", k, v, 32'h11 + 32'(k)); fails++; end
      pop();
    end
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL fpp_drain got %h exp %h", v, 32'h10); fails++; end
    step(1'b1, 29'h55, 1'b0, 1'b0, 4'd3, 64'd0, 1'b1, 3'd1, 4'b0010, 32'h0000_0100);
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0103) begin $display("FAIL epp_stat got %h exp %h", v, 32'h103); fails++; end
    rd(3'd0, v); tests++;
    if (v !== 32'h0000_0055) begin $display("FAIL epp_id got %h exp %h", v, 32'h55); fails++; end
    pop();
  endtask

  task automatic test_irq();
    logic [31:0] v;
    wr(3'd1, 4'b0100, 32'h0001_0000);
    @(negedge clk); #1; tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL irq_empty got %b exp 0", bus.irq); fails++; end
    push(29'h7, 1'b0, 4'd1, 64'd0);
    #1; tests++;
    if (bus.irq !== 1'b1) begin $display("FAIL irq_nonempty got %b exp 1", bus.irq); fails++; end
    pop();
    #1; tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL irq_after_pop got %b exp 0", bus.irq); fails++; end
    pop();
    rd(3'd1, v); tests++;
    if (v !== 32'h0001_0010) begin $display("FAIL irq_pop_empty got %h exp %h", v, 32'h00010010); fails++; end
    wr(3'd1, 4'b0100, 32'h0002_0000);
    for (int i = 0; i < 4; i++) push(29'h40 + 29'(i), 1'b0, 4'd0, 64'd0);
    #1; tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL irq_full_no_ovf got %b exp 0", bus.irq); fails++; end
    push(29'h44, 1'b0, 4'd0, 64'd0);
    #1; tests++;
    if (bus.irq !== 1'b1) begin $display("FAIL irq_ovf got %b exp 1", bus.irq); fails++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    bus.cs = 1'b1;
    bus.rs = 3'd1;
    #1;
    v = bus.q;
    bus.cs = 1'b0;
    tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL rst_mid_stat got %h exp %h", v, 32'h10); fails++; end
    tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL rst_mid_irq got %b exp 0", bus.irq); fails++; end
    @(negedge clk);
    reset = 1'b0;
    rd(3'd1, v); tests++;
    if (v !== 32'h0000_0010) begin $display("FAIL rst_mid_after got %h exp %h", v, 32'h10); fails++; end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.frm_valid = 1'b0;
    bus.frm_id    = '0;
    bus.frm_ext   = 1'b0;
    bus.frm_rtr   = 1'b0;
    bus.frm_dlc   = '0;
    bus.frm_data  = '0;
    bus.cs        = 1'b0;
    bus.rs        = '0;
    bus.bytesel   = '0;
    bus.d         = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_ovf_set_wins();
    test_filter();
    test_full_push_pop();
    test_irq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
